// File: rtl/ram_burst_reader_if.sv
// Bundle of command, RAM read-port and output-stream signals for
// ram_burst_reader. The reader takes the slave view; whatever issues
// commands, owns the RAM and consumes the stream takes the master view.
interface ram_burst_reader_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              ram_port_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              busy;
  logic              done;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, ram_data, out_ready,
    output cmd_ready, ram_port_en, ram_addr, out_valid, out_data, out_last,
           busy, done
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, ram_data, out_ready,
    input  cmd_ready, ram_port_en, ram_addr, out_valid, out_data, out_last,
           busy, done
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Burst read initiator for the 16x8 dual-port RAM: accepts (addr, len),
// reads consecutive words (address wraps at the top of the RAM) and
// streams them out on valid/ready with a last marker and a done pulse.
// Optional feature: define BURST_ABORT_EN to add an 'abort' input that
// cuts a running burst short (done still pulses once).
module ram_burst_reader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 5
) (
  input logic clk,
  input logic rst_n,
`ifdef BURST_ABORT_EN
  input logic abort,
`endif
  ram_burst_reader_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [LEN_W-1:0]  r_remain;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;

  logic w_load;
  logic w_accept_cmd;
  logic w_read;
  logic w_clear;
  logic w_abort;
  logic w_cmd_ready;
  logic w_done;

  // The output register can take a new word when it is empty or being emptied.
  assign w_load = !r_out_valid | bus.out_ready;

`ifdef BURST_ABORT_EN
  assign w_abort = abort & ((r_state == READ) | (r_state == DRAIN));
`else
  assign w_abort = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state and control decode; an empty burst passes through DRAIN with
  // nothing pending so its done pulse lands two cycles after the handshake.
  always_comb begin
    w_next_state = r_state;
    w_accept_cmd = 1'b0;
    w_read       = 1'b0;
    w_clear      = 1'b0;
    w_cmd_ready  = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          w_accept_cmd = 1'b1;
          w_next_state = (bus.cmd_len == '0) ? DRAIN : READ;
        end
      end
      READ: begin
        if (w_load) begin
          w_read = 1'b1;
          if (r_remain == LEN_W'(1)) w_next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (w_load) begin
          w_clear      = 1'b1;
          w_next_state = FIN;
        end
      end
      FIN: begin
        w_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
    if (w_abort) begin
      w_read       = 1'b0;
      w_clear      = 1'b0;
      w_next_state = FIN;
    end
  end

  // Address/count bookkeeping and the output word register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cur_addr  <= '0;
      r_remain    <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_abort) begin
      r_remain    <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_accept_cmd) begin
      r_cur_addr <= bus.cmd_addr;
      r_remain   <= bus.cmd_len;
    end else if (w_read) begin
      r_out_data  <= bus.ram_data;
      r_out_valid <= 1'b1;
      r_out_last  <= (r_remain == LEN_W'(1));
      r_cur_addr  <= r_cur_addr + ADDR_W'(1);
      r_remain    <= r_remain - LEN_W'(1);
    end else if (w_clear) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.ram_port_en = w_read;
  assign bus.ram_addr    = r_cur_addr;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_data    = r_out_data;
  assign bus.out_last    = r_out_last;
  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = w_done;

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a behavioural 16x8 RAM preloaded
// with mem[i] = i*3 and a scoreboard of expected stream words.
module tb_ram_burst_reader;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic clk;
  logic rst_n;
  logic [7:0] mem [16];
`ifdef BURST_ABORT_EN
  logic abort;
`endif

  ram_burst_reader_if #(.ADDR_W(4), .DATA_W(8), .LEN_W(5)) bus ();

  ram_burst_reader #(.ADDR_W(4), .DATA_W(8), .LEN_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef BURST_ABORT_EN
    .abort (abort),
`endif
    .bus   (bus)
  );

  assign bus.ram_data = mem[bus.ram_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int hsCyc = 0;
  int doneCyc = -1;
  int firstValidCyc = -1;
  int doneCnt = 0;
  int hsCount = 0;
  int beats = 0;
  logic stalledPrev = 1'b0;
  logic [7:0] heldData = '0;
  logic heldLast = 1'b0;
  beat_t expq[$];
  int addrLog[$];

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent expected RAM content.
  function automatic logic [7:0] memModel(input int a);
    return 8'((a % 16) * 3);
  endfunction

  // Sample DUT at the falling edge, then move to just after the next rising edge.
  task automatic cycle();
    beat_t e;
    @(negedge clk);
    if (bus.cmd_valid && bus.cmd_ready) hsCount++;
    if (bus.ram_port_en) addrLog.push_back(int'(bus.ram_addr));
    if (bus.done) begin
      doneCnt++;
      doneCyc = cyc;
    end
    if (bus.out_valid && firstValidCyc < 0) firstValidCyc = cyc;
    if (stalledPrev && bus.out_valid) begin
      checkOutput("stall_data_stable", bus.out_data, heldData);
      checkOutput("stall_last_stable", bus.out_last, heldLast);
    end
    if (bus.out_valid && bus.out_ready) begin
      beats++;
      if (expq.size() == 0) begin
        checkOutput("unexpected_beat", bus.out_data, 32'hFFFF_FFFF);
      end else begin
        e = expq.pop_front();
        checkOutput("beat_data", bus.out_data, e.data);
        checkOutput("beat_last", bus.out_last, e.last);
      end
    end
    stalledPrev = bus.out_valid && !bus.out_ready;
    heldData = bus.out_data;
    heldLast = bus.out_last;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic startTest();
    firstValidCyc = -1;
    beats = 0;
    addrLog.delete();
  endtask

  // Present a command for one cycle and push its expected words.
  task automatic applyStimulus(input int addr, input int len);
    beat_t e;
    for (int i = 0; i < len; i++) begin
      e.data = memModel(addr + i);
      e.last = (i == len - 1);
      expq.push_back(e);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = 4'(addr);
    bus.cmd_len = 5'(len);
    hsCyc = cyc;
    cycle();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int base = doneCnt;
    int n = 0;
    while (doneCnt == base && n < budget) begin
      cycle();
      n++;
    end
    checkOutput("done_seen", doneCnt - base, 1);
  endtask

  initial begin
    int hsBase;
    int doneBase;
    int n;
    bit pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int wrapAddr [4] = '{14, 15, 0, 1};

    for (int i = 0; i < 16; i++) mem[i] = 8'(i * 3);
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_addr = '0;
    bus.cmd_len = '0;
    bus.out_ready = 1'b1;
`ifdef BURST_ABORT_EN
    abort = 1'b0;
`endif
    #12;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_last", bus.out_last, 0);
    checkOutput("rst_out_data", bus.out_data, 0);
    checkOutput("rst_done", bus.done, 0);
    checkOutput("rst_port_en", bus.ram_port_en, 0);
    checkOutput("rst_ram_addr", bus.ram_addr, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_cmd_ready", bus.cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic burst addr=2 len=4");
    startTest();
    applyStimulus(2, 4);
    waitDone(40);
    checkOutput("basic_beats", beats, 4);
    checkOutput("basic_first_valid_lat", firstValidCyc - hsCyc, 2);
    checkOutput("basic_done_lat", doneCyc - hsCyc, 6);
    checkOutput("basic_sb_empty", expq.size(), 0);
    checkOutput("basic_idle_ready", bus.cmd_ready, 1);

    $display("[TB] wrap-around addr=14 len=4");
    startTest();
    applyStimulus(14, 4);
    waitDone(40);
    checkOutput("wrap_beats", beats, 4);
    checkOutput("wrap_addr_count", addrLog.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < addrLog.size()) checkOutput("wrap_ram_addr", addrLog[i], wrapAddr[i]);
    checkOutput("wrap_sb_empty", expq.size(), 0);

    $display("[TB] backpressure addr=0 len=3");
    startTest();
    applyStimulus(0, 3);
    cycle();
    for (int k = 0; k < 5; k++) begin
      bus.out_ready = pat[k];
      cycle();
    end
    bus.out_ready = 1'b1;
    waitDone(40);
    checkOutput("bp_beats", beats, 3);
    checkOutput("bp_sb_empty", expq.size(), 0);

    $display("[TB] zero-length command");
    startTest();
    applyStimulus(5, 0);
    waitDone(20);
    checkOutput("len0_no_valid", firstValidCyc, -1);
    checkOutput("len0_done_lat", doneCyc - hsCyc, 2);
    checkOutput("len0_cmd_ready", bus.cmd_ready, 1);

    $display("[TB] cmd_valid held during len=16 burst");
    startTest();
    hsBase = hsCount;
    applyStimulus(3, 16);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr = 4'd9;
    bus.cmd_len = 5'd2;
    waitDone(60);
    checkOutput("hold_beats", beats, 16);
    checkOutput("hold_done_lat", doneCyc - hsCyc, 18);
    checkOutput("hold_single_accept", hsCount - hsBase, 1);
    checkOutput("hold_sb_empty", expq.size(), 0);
    startTest();
    applyStimulus(9, 2);
    checkOutput("hold_second_accept", hsCount - hsBase, 2);
    waitDone(40);
    checkOutput("second_beats", beats, 2);
    checkOutput("second_sb_empty", expq.size(), 0);

    $display("[TB] reset mid-burst");
    startTest();
    doneBase = doneCnt;
    applyStimulus(0, 8);
    n = 0;
    while (beats < 2 && n < 40) begin
      cycle();
      n++;
    end
    checkOutput("mrst_beats_before", beats, 2);
    rst_n = 1'b0;
    #1;
    checkOutput("mrst_out_valid", bus.out_valid, 0);
    checkOutput("mrst_busy", bus.busy, 0);
    checkOutput("mrst_out_last", bus.out_last, 0);
    expq.delete();
    for (int i = 0; i < 3; i++) cycle();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) cycle();
    checkOutput("mrst_no_done", doneCnt - doneBase, 0);
    checkOutput("mrst_beats_total", beats, 2);
    checkOutput("mrst_cmd_ready", bus.cmd_ready, 1);

`ifdef BURST_ABORT_EN
    $display("[TB] abort after two beats");
    startTest();
    doneBase = doneCnt;
    applyStimulus(4, 8);
    n = 0;
    while (beats < 2 && n < 40) begin
      cycle();
      n++;
    end
    bus.out_ready = 1'b0;
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("abort_out_valid", bus.out_valid, 0);
    waitDone(10);
    expq.delete();
    for (int i = 0; i < 3; i++) cycle();
    checkOutput("abort_beats", beats, 2);
    checkOutput("abort_one_done", doneCnt - doneBase, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
